// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - tile ids, keycodes, direction and FSM types shared by the knight move logic
package game_pkg;

  localparam logic [7:0] TILE_FLOOR  = 8'd0;
  localparam logic [7:0] TILE_WALL   = 8'd1;
  localparam logic [7:0] TILE_DOOR_Y = 8'd2;
  localparam logic [7:0] TILE_KEY_Y  = 8'd3;
  localparam logic [7:0] TILE_STAIR  = 8'd4;

  localparam logic [12:0] FLOOR_WORD = 13'd0;

  localparam logic [7:0] KC_W = 8'h1A;
  localparam logic [7:0] KC_S = 8'h16;
  localparam logic [7:0] KC_A = 8'h04;
  localparam logic [7:0] KC_D = 8'h07;

  // Encoding matches the drawer's knight direction field
  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, DECIDE = 2'd2, HOLD = 2'd3} state_t;

  function automatic logic key_valid(input logic [7:0] kc);
    return (kc == KC_W) || (kc == KC_S) || (kc == KC_A) || (kc == KC_D);
  endfunction

  function automatic dir_t key_dir(input logic [7:0] kc);
    case (kc)
      KC_W:    return UP;
      KC_S:    return DOWN;
      KC_A:    return LEFT;
      default: return RIGHT;
    endcase
  endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// rtl/key_repeat_timer.sv - counts frame ticks while a key is held and fires every REPEAT_FRAMES
module key_repeat_timer #(
  parameter int REPEAT_FRAMES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic repeat_fire
);
  localparam int CW = $clog2(REPEAT_FRAMES + 1);

  logic [CW-1:0] count;

  // Fires on the tick that completes the period, so the counter restarts from zero
  assign repeat_fire = enable && tick && (count == CW'(REPEAT_FRAMES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || repeat_fire) begin
      count <= '0;
    end else if (enable && tick) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/knight_move_controller.sv
// rtl/knight_move_controller.sv - keycode to knight move FSM with map lookup and door/key updates
module knight_move_controller
  import game_pkg::*;
#(
  parameter int MAP_DIM       = 11,
  parameter int START_X       = 5,
  parameter int START_Y       = 10,
  parameter int REPEAT_FRAMES = 8,
  parameter int KEY_MAX       = 15
) (
  input  logic        CLK,
  input  logic        RESET_H,
  input  logic        FRAME_TICK,
  input  logic [7:0]  Keycode,
  output logic [3:0]  MapRdX,
  output logic [3:0]  MapRdY,
  input  logic [12:0] MapRdData,
  output logic        MapWrEn,
  output logic [3:0]  MapWrX,
  output logic [3:0]  MapWrY,
  output logic [12:0] MapWrData,
  output logic [3:0]  KnightX,
  output logic [3:0]  KnightY,
  output logic [3:0]  KeyCount,
  output logic        StairPulse
);
  localparam logic signed [4:0] DIM_S = 5'(MAP_DIM);

  state_t            state;
  logic [7:0]        key_q;
  logic signed [4:0] tgt_x;
  logic signed [4:0] tgt_y;
  logic              in_bounds;
  logic              key_ok;
  logic              same_key;
  logic              repeat_fire;
  logic              unused_tile_hi;

  assign key_ok         = key_valid(Keycode);
  assign same_key       = (Keycode == key_q);
  assign unused_tile_hi = ^MapRdData[12:8];

  // Signed so that stepping off the top/left edge shows up as a negative target
  always_comb begin
    tgt_x = $signed({1'b0, KnightX});
    tgt_y = $signed({1'b0, KnightY});
    case (key_dir(Keycode))
      UP:    tgt_y = tgt_y - 5'sd1;
      DOWN:  tgt_y = tgt_y + 5'sd1;
      LEFT:  tgt_x = tgt_x - 5'sd1;
      RIGHT: tgt_x = tgt_x + 5'sd1;
    endcase
  end

  assign in_bounds = (tgt_x >= 5'sd0) && (tgt_x < DIM_S) &&
                     (tgt_y >= 5'sd0) && (tgt_y < DIM_S);

  key_repeat_timer #(
    .REPEAT_FRAMES(REPEAT_FRAMES)
  ) u_repeat (
    .clk        (CLK),
    .reset      (RESET_H),
    .clear      (state != HOLD),
    .enable     ((state == HOLD) && same_key),
    .tick       (FRAME_TICK),
    .repeat_fire(repeat_fire)
  );

  always_ff @(posedge CLK) begin
    if (RESET_H) begin
      state      <= IDLE;
      key_q      <= 8'h00;
      KnightX    <= 4'(START_X);
      KnightY    <= 4'(START_Y);
      KeyCount   <= 4'd0;
      MapRdX     <= 4'd0;
      MapRdY     <= 4'd0;
      MapWrEn    <= 1'b0;
      MapWrX     <= 4'd0;
      MapWrY     <= 4'd0;
      MapWrData  <= 13'd0;
      StairPulse <= 1'b0;
    end else begin
      MapWrEn    <= 1'b0;
      StairPulse <= 1'b0;
      case (state)
        IDLE: begin
          if (key_ok) begin
            key_q <= Keycode;
            if (in_bounds) begin
              MapRdX <= tgt_x[3:0];
              MapRdY <= tgt_y[3:0];
              state  <= RD;
            end else begin
              state <= HOLD;
            end
          end
        end
        RD: state <= DECIDE;
        DECIDE: begin
          // MapRdX/Y still hold the target tile for the whole decision
          case (MapRdData[7:0])
            TILE_FLOOR: begin
              KnightX <= MapRdX;
              KnightY <= MapRdY;
            end
            TILE_DOOR_Y: begin
              if (KeyCount != 4'd0) begin
                MapWrEn   <= 1'b1;
                MapWrX    <= MapRdX;
                MapWrY    <= MapRdY;
                MapWrData <= FLOOR_WORD;
                KeyCount  <= KeyCount - 4'd1;
              end
            end
            TILE_KEY_Y: begin
              MapWrEn   <= 1'b1;
              MapWrX    <= MapRdX;
              MapWrY    <= MapRdY;
              MapWrData <= FLOOR_WORD;
              if (KeyCount != 4'(KEY_MAX)) KeyCount <= KeyCount + 4'd1;
              KnightX   <= MapRdX;
              KnightY   <= MapRdY;
            end
            TILE_STAIR: StairPulse <= 1'b1;
            default: ;
          endcase
          state <= HOLD;
        end
        HOLD: begin
          if ((Keycode == 8'h00) || (key_ok && !same_key) || repeat_fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_knight_move_controller.sv
// tb/tb_knight_move_controller.sv - scoreboard bench for knight_move_controller
module tb_knight_move_controller;
  import game_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET_H = 1'b1;
  logic        FRAME_TICK = 1'b0;
  logic [7:0]  Keycode = 8'h00;
  logic [3:0]  MapRdX, MapRdY, MapWrX, MapWrY, KnightX, KnightY, KeyCount;
  logic [12:0] MapRdData, MapWrData;
  logic        MapWrEn, StairPulse;

  always #5 CLK = ~CLK;

  knight_move_controller dut (
    .CLK(CLK), .RESET_H(RESET_H), .FRAME_TICK(FRAME_TICK), .Keycode(Keycode),
    .MapRdX(MapRdX), .MapRdY(MapRdY), .MapRdData(MapRdData),
    .MapWrEn(MapWrEn), .MapWrX(MapWrX), .MapWrY(MapWrY), .MapWrData(MapWrData),
    .KnightX(KnightX), .KnightY(KnightY), .KeyCount(KeyCount), .StairPulse(StairPulse)
  );

  typedef struct packed {logic [3:0] x; logic [3:0] y; logic [3:0] k;} pos_t;

  logic [12:0] map [0:15][0:15];
  pos_t        exp_q[$];
  logic [20:0] obs_wr[$];
  int          stair_cycles = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  // Map RAM model with one-cycle read latency; writes are logged and applied by the tests
  always @(posedge CLK) begin
    MapRdData <= map[MapRdY][MapRdX];
    if (MapWrEn) obs_wr.push_back({MapWrX, MapWrY, MapWrData});
    if (StairPulse) stair_cycles <= stair_cycles + 1;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic do_reset();
    RESET_H = 1'b1; Keycode = 8'h00; FRAME_TICK = 1'b0;
    step(2);
    RESET_H = 1'b0;
    step(1);
    obs_wr.delete();
  endtask

  task automatic press(input logic [7:0] kc);
    Keycode = kc;
    step(4);
    Keycode = 8'h00;
    step(2);
  endtask

  task automatic frame();
    FRAME_TICK = 1'b1;
    step(1);
    FRAME_TICK = 1'b0;
    step(4);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({KnightX, KnightY, KeyCount} !== {4'd5, 4'd10, 4'd0}) begin
      n_bad++; $display("FAIL reset_pos got x=%0d y=%0d k=%0d want 5 10 0", KnightX, KnightY, KeyCount);
    end
    n_vec++;
    if ({MapWrEn, StairPulse} !== 2'b00) begin
      n_bad++; $display("FAIL reset_strobes got wr=%b stair=%b want 0 0", MapWrEn, StairPulse);
    end
    n_vec++;
    if ({MapRdX, MapRdY, MapWrX, MapWrY, MapWrData} !== 29'd0) begin
      n_bad++; $display("FAIL reset_addr got rd=%0d,%0d wr=%0d,%0d data=%h want all 0", MapRdX, MapRdY, MapWrX, MapWrY, MapWrData);
    end
  endtask

  task automatic test_floor_move();
    pos_t e;
    map[9][5] = {5'h15, TILE_FLOOR};
    exp_q.push_back({4'd5, 4'd9, 4'd0});
    Keycode = KC_W;
    step(1);
    n_vec++;
    if ({MapRdX, MapRdY} !== {4'd5, 4'd9}) begin
      n_bad++; $display("FAIL floor_read_addr got %0d,%0d want 5,9", MapRdX, MapRdY);
    end
    step(1);
    n_vec++;
    if (KnightY !== 4'd10) begin
      n_bad++; $display("FAIL floor_early_move got y=%0d want 10", KnightY);
    end
    step(1);
    e = exp_q.pop_front();
    n_vec++;
    if ({KnightX, KnightY, KeyCount} !== e) begin
      n_bad++; $display("FAIL floor_move got x=%0d y=%0d k=%0d want %0d %0d %0d", KnightX, KnightY, KeyCount, e.x, e.y, e.k);
    end
    step(1);
    Keycode = 8'h00;
    step(2);
    n_vec++;
    if (obs_wr.size() !== 0) begin
      n_bad++; $display("FAIL floor_no_write got %0d writes want 0", obs_wr.size());
    end
    obs_wr.delete();
  endtask

  task automatic test_key_door_stair();
    pos_t e;
    int s0;
    logic [7:0]  kcs [0:6];
    pos_t        exps[0:6];
    logic [20:0] wrs [0:6];
    do_reset();
    map[10][6] = {5'h0, TILE_KEY_Y};
    map[9][6]  = {5'h0, TILE_DOOR_Y};
    map[8][6]  = {5'h0, TILE_STAIR};
    map[9][7]  = {5'h0, TILE_DOOR_Y};
    // key pickup, door open, onto door, stair, locked door
    kcs[0] = KC_D; exps[0] = {4'd6, 4'd10, 4'd1}; wrs[0] = {4'd6, 4'd10, FLOOR_WORD};
    kcs[1] = KC_W; exps[1] = {4'd6, 4'd10, 4'd0}; wrs[1] = {4'd6, 4'd9, FLOOR_WORD};
    kcs[2] = KC_W; exps[2] = {4'd6, 4'd9, 4'd0};  wrs[2] = '1;
    kcs[3] = KC_W; exps[3] = {4'd6, 4'd9, 4'd0};  wrs[3] = '1;
    kcs[4] = KC_D; exps[4] = {4'd6, 4'd9, 4'd0};  wrs[4] = '1;
    kcs[5] = KC_D; exps[5] = {4'd6, 4'd9, 4'd0};  wrs[5] = '1;
    kcs[6] = KC_D; exps[6] = {4'd6, 4'd9, 4'd0};  wrs[6] = '1;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) map[9][7] = {5'h1F, TILE_WALL};
      if (i == 6) map[9][7] = {5'h00, 8'h7F};
      s0 = stair_cycles;
      exp_q.push_back(exps[i]);
      press(kcs[i]);
      e = exp_q.pop_front();
      n_vec++;
      if ({KnightX, KnightY, KeyCount} !== e) begin
        n_bad++; $display("FAIL tile_step%0d got x=%0d y=%0d k=%0d want %0d %0d %0d", i, KnightX, KnightY, KeyCount, e.x, e.y, e.k);
      end
      n_vec++;
      if (wrs[i] === '1 ? (obs_wr.size() !== 0) : (obs_wr.size() !== 1 || obs_wr[0] !== wrs[i])) begin
        n_bad++; $display("FAIL tile_write%0d got %0d writes first=%h want %h", i, obs_wr.size(), obs_wr.size() > 0 ? obs_wr[0] : 21'h0, wrs[i]);
      end
      while (obs_wr.size() > 0) begin
        logic [20:0] w;
        w = obs_wr.pop_front();
        map[w[16:13]][w[20:17]] = w[12:0];
      end
      n_vec++;
      if (stair_cycles - s0 !== (i == 3 ? 1 : 0)) begin
        n_bad++; $display("FAIL stair_pulse%0d got %0d cycles want %0d", i, stair_cycles - s0, i == 3 ? 1 : 0);
      end
    end
  endtask

  task automatic test_repeat();
    pos_t e;
    do_reset();
    exp_q.push_back({4'd5, 4'd9, 4'd0});
    Keycode = KC_W;
    step(4);
    e = exp_q.pop_front();
    n_vec++;
    if ({KnightX, KnightY, KeyCount} !== e) begin
      n_bad++; $display("FAIL repeat_first got y=%0d want %0d", KnightY, e.y);
    end
    for (int f = 1; f <= 24; f++) begin
      exp_q.push_back({4'd5, 4'(9 - f / 8), 4'd0});
      frame();
      e = exp_q.pop_front();
      n_vec++;
      if ({KnightX, KnightY, KeyCount} !== e) begin
        n_bad++; $display("FAIL repeat_frame%0d got x=%0d y=%0d want %0d %0d", f, KnightX, KnightY, e.x, e.y);
      end
    end
    Keycode = 8'h00;
    step(2);
    Keycode = KC_S;
    step(2);
    n_vec++;
    if (KnightY !== 4'd6) begin
      n_bad++; $display("FAIL release_idle_early got y=%0d want 6", KnightY);
    end
    step(1);
    n_vec++;
    if (KnightY !== 4'd7) begin
      n_bad++; $display("FAIL release_idle_move got y=%0d want 7", KnightY);
    end
    step(1);
    Keycode = 8'h00;
    step(2);
  endtask

  task automatic test_reset_in_decide();
    do_reset();
    map[10][6] = {5'h0, TILE_KEY_Y};
    Keycode = KC_D;
    step(2);
    RESET_H = 1'b1;
    step(1);
    RESET_H = 1'b0;
    Keycode = 8'h00;
    step(2);
    n_vec++;
    if ({KnightX, KnightY, KeyCount} !== {4'd5, 4'd10, 4'd0}) begin
      n_bad++; $display("FAIL abort_pos got x=%0d y=%0d k=%0d want 5 10 0", KnightX, KnightY, KeyCount);
    end
    n_vec++;
    if (obs_wr.size() !== 0) begin
      n_bad++; $display("FAIL abort_write got %0d writes want 0", obs_wr.size());
    end
    obs_wr.delete();
  endtask

  task automatic test_out_of_bounds();
    pos_t e;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(i < 10 ? {4'd5, 4'(9 - i), 4'd0} : {4'(14 - i), 4'd0, 4'd0});
      press(i < 10 ? KC_W : KC_A);
      e = exp_q.pop_front();
      n_vec++;
      if ({KnightX, KnightY, KeyCount} !== e) begin
        n_bad++; $display("FAIL walk%0d got x=%0d y=%0d want %0d %0d", i, KnightX, KnightY, e.x, e.y);
      end
    end
    Keycode = KC_A;
    step(2);
    for (int f = 1; f <= 30; f++) begin
      frame();
      n_vec++;
      if ({KnightX, KnightY, MapRdX, MapRdY} !== 16'h0000) begin
        n_bad++; $display("FAIL oob_frame%0d got pos=%0d,%0d rd=%0d,%0d want 0,0 0,0", f, KnightX, KnightY, MapRdX, MapRdY);
      end
    end
    Keycode = KC_S;
    step(5);
    n_vec++;
    if ({KnightX, KnightY} !== {4'd0, 4'd1}) begin
      n_bad++; $display("FAIL b2b_first got %0d,%0d want 0,1", KnightX, KnightY);
    end
    Keycode = KC_D;
    step(5);
    n_vec++;
    if ({KnightX, KnightY} !== {4'd1, 4'd1}) begin
      n_bad++; $display("FAIL b2b_second got %0d,%0d want 1,1", KnightX, KnightY);
    end
    Keycode = 8'h00;
    step(2);
  endtask

  initial begin
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        map[y][x] = FLOOR_WORD;
    test_reset();
    test_floor_move();
    test_key_door_stair();
    test_repeat();
    test_reset_in_decide();
    test_out_of_bounds();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
